pc_gen: RTL

Parametrised program-counter generator for the instruction-fetch stage, driving the instruction-memory address and chip-enable. Adds to the basic PC register:
- configurable width, reset vector and fetch stride;
- a memory-grant handshake;
- flush and branch redirects, with a one-entry pending-branch buffer so a redirect that arrives during a stall or wait is not lost;
- misalignment flag and saturating fetch counter.

Sits between the ctrl block (stall/flush), the ID stage (branch) and the instruction ROM.

---
 rtl/pc_gen.sv | 120 ++++++++++++
 1 files changed

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - instruction-fetch program counter with grant handshake and branch buffer
//
// Ports:
//   clk            clock
//   rst            synchronous active-high reset
//   stall          stall vector from ctrl; only stall[0] holds the PC
//   flush          redirect to new_pc; highest priority after reset
//   new_pc         flush target
//   branch_flag    branch/jump taken from ID
//   branch_target  branch destination
//   if_gnt         instruction memory accepts pc this cycle
//   pc             current fetch address
//   ce             instruction-memory chip enable / fetch request
//   misalign       ce and pc not aligned to INC
//   fetch_cnt      saturating count of accepted fetches
module pc_gen #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int                INC       = 4,
  parameter int                STALL_W   = 6,
  parameter int                CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  new_pc,
  input  logic               branch_flag,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic               if_gnt,
  output logic [ADDR_W-1:0]  pc,
  output logic               ce,
  output logic               misalign,
  output logic [CNT_W-1:0]   fetch_cnt
);

  localparam int                LSB_W = $clog2(INC);
  localparam logic [ADDR_W-1:0] INC_V = ADDR_W'(INC);

  typedef enum logic {
    OFF = 1'b0,
    RUN = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc_nxt;
  logic              pend_valid, pend_valid_nxt;
  logic [ADDR_W-1:0] pend_target, pend_target_nxt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              adv;
  logic              stall_unused;

  // Upper stall bits belong to later pipeline stages.
  assign stall_unused = ^stall;

  assign ce       = (state == RUN);
  assign adv      = ce & ~stall[0] & if_gnt;
  assign misalign = ce & (|pc[LSB_W-1:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= OFF;
      pc          <= RESET_VEC;
      pend_valid  <= 1'b0;
      pend_target <= '0;
      fetch_cnt   <= '0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      pend_valid  <= pend_valid_nxt;
      pend_target <= pend_target_nxt;
      fetch_cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    pend_valid_nxt  = pend_valid;
    pend_target_nxt = pend_target;
    cnt_nxt         = fetch_cnt;

    case (state)
      OFF: begin
        // One idle cycle at RESET_VEC so the first fetch address is stable
        // before any advance can happen.
        state_nxt = RUN;
        pc_nxt    = RESET_VEC;
      end

      RUN: begin
        if (flush) begin
          pc_nxt         = new_pc;
          pend_valid_nxt = 1'b0;
        end else if (adv && branch_flag) begin
          // A fresh branch supersedes anything still buffered.
          pc_nxt         = branch_target;
          pend_valid_nxt = 1'b0;
        end else if (adv && pend_valid) begin
          pc_nxt         = pend_target;
          pend_valid_nxt = 1'b0;
        end else if (adv) begin
          pc_nxt = pc + INC_V;
        end else if (branch_flag) begin
          // Redirect arrived while the fetch is stalled or ungranted: keep
          // the latest one until the next accepted fetch.
          pend_valid_nxt  = 1'b1;
          pend_target_nxt = branch_target;
        end

        if (adv && !flush && (fetch_cnt != {CNT_W{1'b1}})) begin
          cnt_nxt = fetch_cnt + CNT_W'(1);
        end
      end

      default: state_nxt = OFF;
    endcase
  end

endmodule
